fme_mv_cmp: RTL and testbench

- Cost-compare and fractional-MV writer for FME.
- Receives per-candidate costs for each 8x8 block during the half-pel and quarter-pel passes.
- Picks the minimum-cost candidate and writes the refined MV into a 64-entry MV buffer.
- Is the responder to the FME controller: serves its `mcif_mv` read port and returns the `cost_done` handshake that advances the controller's pass state.

---
 rtl/fme_mv_cmp_pkg.sv | 46 ++++
 rtl/fme_mv_buf_64.sv | 39 +++
 rtl/fme_mv_cmp.sv | 129 ++++++++++++
 tb/tb_fme_mv_cmp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_mv_cmp_pkg.sv
// Shared definitions for the FME cost-compare / fractional-MV writer:
// widths, FSM encoding, candidate offset table and buffer address mapping.
package fme_mv_cmp_pkg;

  localparam int FMV_WIDTH  = 10;
  localparam int COST_WIDTH = 16;
  localparam int MV_W       = 2 * FMV_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_QUAR = 2'd2,
    ST_DONE = 2'd3
  } fme_state_e;

  // Horizontal unit offset of a candidate; indices 9..15 fall into the (0,0) default.
  function automatic logic [1:0] cand_dx(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd6: cand_dx = 2'b11;
      4'd3, 4'd5, 4'd8: cand_dx = 2'b01;
      default:          cand_dx = 2'b00;
    endcase
  endfunction

  // Vertical unit offset of a candidate (negative = up).
  function automatic logic [1:0] cand_dy(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd2, 4'd3: cand_dy = 2'b11;
      4'd6, 4'd7, 4'd8: cand_dy = 2'b01;
      default:          cand_dy = 2'b00;
    endcase
  endfunction

  // Sign-extend a unit offset to MV width and apply the pass step (2 half-pel, 1 quarter-pel).
  function automatic logic [FMV_WIDTH-1:0] off_scale(input logic [1:0] d, input logic half);
    logic [FMV_WIDTH-1:0] ext;
    ext = {{(FMV_WIDTH-2){d[1]}}, d};
    off_scale = half ? {ext[FMV_WIDTH-2:0], 1'b0} : ext;
  endfunction

  // Block index {cnt32,cnt16,cnt08} to raster buffer address {y2,y1,y0,x2,x1,x0}.
  function automatic logic [5:0] mv_addr(input logic [5:0] blk);
    mv_addr = {blk[5], blk[3], blk[1], blk[4], blk[2], blk[0]};
  endfunction

endpackage

// File: rtl/fme_mv_buf_64.sv
// 64-entry MV store: async read for the quarter-pel base fetch, one write
// port for block commits and a registered read-first port for the MC fetch.
module fme_mv_buf_64
  import fme_mv_cmp_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [5:0]      waddr,
  input  logic [MV_W-1:0] wdata,
  input  logic [5:0]      araddr,
  output logic [MV_W-1:0] ardata,
  input  logic            rden,
  input  logic [5:0]      rdaddr,
  output logic [MV_W-1:0] rdata
);

  logic [MV_W-1:0] mem_reg [64];
  logic [MV_W-1:0] rdata_reg;

  // Storage array; cleared on reset so a fresh sequence never sees stale MVs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mem_reg[i] <= '0;
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Registered read port; sampling before the write lands gives read-first behaviour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     rdata_reg <= '0;
    else if (rden) rdata_reg <= mem_reg[rdaddr];
  end

  assign ardata = mem_reg[araddr];
  assign rdata  = rdata_reg;

endmodule

// File: rtl/fme_mv_cmp.sv
// FME cost compare: tracks the minimum-cost candidate of each 8x8 block
// during a half- or quarter-pel pass and commits base + offset*step to the
// MV buffer; signals pass completion to the FME controller.
module fme_mv_cmp
  import fme_mv_cmp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  half_flag_i,
  input  logic [5:0]            blk_idx_i,
  input  logic [MV_W-1:0]       base_mv_i,
  input  logic                  cand_valid_i,
  input  logic [3:0]            cand_idx_i,
  input  logic [COST_WIDTH-1:0] cand_cost_i,
  input  logic                  mcif_mv_rden_i,
  input  logic [5:0]            mcif_mv_rdaddr_i,
  output logic [MV_W-1:0]       mcif_mv_data_o,
  output logic                  cost_done_o,
  output logic                  busy_o
);

  fme_state_e            state_reg;
  logic [6:0]            blk_cnt_reg;
  logic [3:0]            cand_cnt_reg;
  logic [COST_WIDTH-1:0] min_cost_reg;
  logic [3:0]            min_idx_reg;
  logic [5:0]            blk_reg;
  logic [MV_W-1:0]       base_reg;
  logic                  done_reg;
  logic                  busy_reg;

  logic                  is_half;
  logic                  cand_fire;
  logic                  first_cand;
  logic                  last_cand;
  logic                  take;
  logic [3:0]            idx_norm;
  logic [3:0]            win_idx;
  logic [5:0]            cur_blk;
  logic [MV_W-1:0]       cur_base;
  logic [MV_W-1:0]       buf_base;
  logic [FMV_WIDTH-1:0]  new_x;
  logic [FMV_WIDTH-1:0]  new_y;

  // Candidate datapath: pick the running winner including the current candidate.
  always_comb begin
    is_half    = (state_reg == ST_HALF);
    cand_fire  = cand_valid_i && ((state_reg == ST_HALF) || (state_reg == ST_QUAR));
    first_cand = (cand_cnt_reg == 4'd0);
    last_cand  = (cand_cnt_reg == 4'd8);
    idx_norm   = (cand_idx_i > 4'd8) ? 4'd0 : cand_idx_i;
    cur_blk    = first_cand ? blk_idx_i : blk_reg;
    cur_base   = base_reg;
    if (first_cand) cur_base = is_half ? base_mv_i : buf_base;
    take       = first_cand || (cand_cost_i < min_cost_reg);
    win_idx    = take ? idx_norm : min_idx_reg;
    new_x      = cur_base[MV_W-1:FMV_WIDTH] + off_scale(cand_dx(win_idx), is_half);
    new_y      = cur_base[FMV_WIDTH-1:0]    + off_scale(cand_dy(win_idx), is_half);
  end

  fme_mv_buf_64 u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .we     (cand_fire && last_cand),
    .waddr  (mv_addr(cur_blk)),
    .wdata  ({new_x, new_y}),
    .araddr (mv_addr(blk_idx_i)),
    .ardata (buf_base),
    .rden   (mcif_mv_rden_i),
    .rdaddr (mcif_mv_rdaddr_i),
    .rdata  (mcif_mv_data_o)
  );

  // Pass FSM with per-block candidate tracking and registered busy/done flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      blk_cnt_reg  <= '0;
      cand_cnt_reg <= '0;
      min_cost_reg <= '0;
      min_idx_reg  <= '0;
      blk_reg      <= '0;
      base_reg     <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg    <= half_flag_i ? ST_HALF : ST_QUAR;
            busy_reg     <= 1'b1;
            blk_cnt_reg  <= '0;
            cand_cnt_reg <= '0;
          end
        end
        ST_HALF, ST_QUAR: begin
          if (cand_fire) begin
            cand_cnt_reg <= last_cand ? 4'd0 : cand_cnt_reg + 4'd1;
            if (first_cand) begin
              blk_reg  <= blk_idx_i;
              base_reg <= cur_base;
            end
            if (take) begin
              min_cost_reg <= cand_cost_i;
              min_idx_reg  <= idx_norm;
            end
            if (last_cand) begin
              blk_cnt_reg <= blk_cnt_reg + 7'd1;
              if (blk_cnt_reg == 7'd63) begin
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cost_done_o = done_reg;
  assign busy_o      = busy_reg;

endmodule

// File: tb/tb_fme_mv_cmp.sv
// Directed bench for fme_mv_cmp: half/quarter passes, ties, index aliasing,
// address mapping, read-first, MV wrap and mid-pass reset.
module tb_fme_mv_cmp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic        half_flag_i;
  logic [5:0]  blk_idx_i;
  logic [19:0] base_mv_i;
  logic        cand_valid_i;
  logic [3:0]  cand_idx_i;
  logic [15:0] cand_cost_i;
  logic        mcif_mv_rden_i;
  logic [5:0]  mcif_mv_rdaddr_i;
  logic [19:0] mcif_mv_data_o;
  logic        cost_done_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fme_mv_cmp dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_i          (start_i),
    .half_flag_i      (half_flag_i),
    .blk_idx_i        (blk_idx_i),
    .base_mv_i        (base_mv_i),
    .cand_valid_i     (cand_valid_i),
    .cand_idx_i       (cand_idx_i),
    .cand_cost_i      (cand_cost_i),
    .mcif_mv_rden_i   (mcif_mv_rden_i),
    .mcif_mv_rdaddr_i (mcif_mv_rdaddr_i),
    .mcif_mv_data_o   (mcif_mv_data_o),
    .cost_done_o      (cost_done_o),
    .busy_o           (busy_o)
  );

  always @(posedge clk) if (cost_done_o) done_cnt++;

  function automatic logic [19:0] mv(input int x, input int y);
    logic [9:0] xs;
    logic [9:0] ys;
    xs = x[9:0];
    ys = y[9:0];
    return {xs, ys};
  endfunction

  task automatic send(input int idx, input int cost, input logic [5:0] blk, input logic [19:0] base);
    @(negedge clk);
    cand_valid_i = 1'b1;
    cand_idx_i   = idx[3:0];
    cand_cost_i  = cost[15:0];
    blk_idx_i    = blk;
    base_mv_i    = base;
  endtask

  // Nine candidates in index order; the winner gets cost 10, the rest are higher.
  // Later candidates carry junk block/base values that must be ignored.
  task automatic send_block(input logic [5:0] blk, input logic [19:0] base, input int win);
    for (int i = 0; i < 9; i++)
      send(i, (i == win) ? 10 : 200 + i, (i == 0) ? blk : ~blk, (i == 0) ? base : ~base);
  endtask

  task automatic quiet();
    @(negedge clk);
    cand_valid_i   = 1'b0;
    mcif_mv_rden_i = 1'b0;
    start_i        = 1'b0;
  endtask

  task automatic start_pass(input logic half);
    @(negedge clk);
    cand_valid_i = 1'b0;
    start_i      = 1'b1;
    half_flag_i  = half;
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL start_busy: busy_o=%b expected 1", busy_o);
    end
  endtask

  task automatic read_chk(input string name, input logic [5:0] addr, input logic [19:0] exp);
    @(negedge clk);
    cand_valid_i     = 1'b0;
    mcif_mv_rden_i   = 1'b1;
    mcif_mv_rdaddr_i = addr;
    @(negedge clk);
    mcif_mv_rden_i = 1'b0;
    total++;
    if (mcif_mv_data_o !== exp) begin
      bad++;
      $display("FAIL %s: addr=%0d data=%h expected %h", name, addr, mcif_mv_data_o, exp);
    end else
      $display("read %s addr=%0d data=%h", name, addr, mcif_mv_data_o);
  endtask

  // Last candidate was just driven: done must rise for exactly one cycle after the commit edge.
  task automatic check_done_pulse(input string name);
    @(negedge clk);
    cand_valid_i = 1'b0;
    total++;
    if (cost_done_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_rise: cost_done_o=%b busy_o=%b expected 1/0", name, cost_done_o, busy_o);
    end
    @(negedge clk);
    total++;
    if (cost_done_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_fall: cost_done_o=%b expected 0", name, cost_done_o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start_i = 1'b0; half_flag_i = 1'b0; blk_idx_i = '0; base_mv_i = '0;
    cand_valid_i = 1'b0; cand_idx_i = '0; cand_cost_i = '0;
    mcif_mv_rden_i = 1'b0; mcif_mv_rdaddr_i = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || cost_done_o !== 1'b0 || mcif_mv_data_o !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b data=%h expected 0/0/0", busy_o, cost_done_o, mcif_mv_data_o);
    end else
      $display("reset outputs ok");
    read_chk("reset_buf", 6'd35, 20'h0);
  endtask

  task automatic test_half_pass();
    start_pass(1'b1);
    for (int b = 0; b < 64; b++) begin
      if (b == 1) begin
        // all costs equal; first arrival (candidate 3) must be kept
        send(3, 100, 6'd1, mv(8, -4));
        for (int i = 0; i < 9; i++) if (i != 3) send(i, 100, 6'd62, mv(0, 0));
      end else if (b == 2) begin
        // alias index 13 arrives last with the lowest cost and acts as candidate 0
        for (int i = 1; i < 9; i++) send(i, 90, (i == 1) ? 6'd2 : 6'd61, (i == 1) ? mv(8, -4) : mv(1, 1));
        send(13, 5, 6'd60, mv(1, 1));
      end else begin
        send_block(b[5:0], mv(8, -4), (b == 0) ? 5 : (b == 37) ? 8 : 0);
      end
      if (b == 20) begin
        // stray quarter-pel start mid-pass must be ignored
        @(negedge clk);
        cand_valid_i = 1'b0; start_i = 1'b1; half_flag_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b1) begin
          bad++;
          $display("FAIL half_start_ignored: busy_o=%b expected 1", busy_o);
        end
      end
    end
    check_done_pulse("half");
    read_chk("half_blk0", 6'd0, mv(10, -4));
    read_chk("half_tie", 6'd1, mv(10, -6));
    read_chk("half_alias", 6'd8, mv(8, -4));
    read_chk("half_map37", 6'd35, mv(10, -2));
    @(negedge clk);
    total++;
    if (mcif_mv_data_o !== mv(10, -2)) begin
      bad++;
      $display("FAIL read_hold: data=%h expected %h", mcif_mv_data_o, mv(10, -2));
    end
    read_chk("half_blk63", 6'd63, mv(8, -4));
  endtask

  task automatic test_quar_pass();
    start_pass(1'b0);
    for (int b = 0; b < 64; b++) begin
      send_block(b[5:0], mv(100, 100), (b == 0) ? 1 : (b == 37) ? 7 : 0);
      if (b == 37) begin
        // read the entry being committed on this same edge
        mcif_mv_rden_i   = 1'b1;
        mcif_mv_rdaddr_i = 6'd35;
        @(negedge clk);
        cand_valid_i   = 1'b0;
        mcif_mv_rden_i = 1'b0;
        total++;
        if (mcif_mv_data_o !== mv(10, -2)) begin
          bad++;
          $display("FAIL read_first: data=%h expected %h", mcif_mv_data_o, mv(10, -2));
        end else
          $display("read read_first addr=35 data=%h", mcif_mv_data_o);
      end
    end
    check_done_pulse("quar");
    read_chk("quar_blk0", 6'd0, mv(9, -5));
    read_chk("quar_map37", 6'd35, mv(10, -1));
    read_chk("quar_tie_kept", 6'd1, mv(10, -6));
  endtask

  task automatic test_wrap();
    start_pass(1'b1);
    for (int b = 0; b < 64; b++)
      send_block(b[5:0], (b == 0) ? mv(511, 0) : mv(0, 0), (b == 0) ? 5 : 0);
    check_done_pulse("wrap");
    read_chk("wrap_x", 6'd0, mv(-511, 0));
    read_chk("wrap_other", 6'd35, mv(0, 0));
  endtask

  task automatic test_reset_mid_pass();
    int done_before;
    done_before = done_cnt;
    start_pass(1'b0);
    for (int b = 0; b < 10; b++) send_block(b[5:0], mv(0, 0), 0);
    for (int i = 0; i < 4; i++) send(i, 50 + i, 6'd10, mv(0, 0));
    // leave a nonzero value on the read port and poke start while busy
    read_chk("pre_reset_rd", 6'd0, mv(-511, 0));
    @(negedge clk);
    start_i = 1'b1; half_flag_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_ignored: busy_o=%b expected 1", busy_o);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || cost_done_o !== 1'b0 || mcif_mv_data_o !== 20'h0) begin
      bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b data=%h expected 0/0/0", busy_o, cost_done_o, mcif_mv_data_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== done_before) begin
      bad++;
      $display("FAIL midreset_no_done: done pulses=%0d expected 0", done_cnt - done_before);
    end
    read_chk("midreset_buf0", 6'd0, 20'h0);
    read_chk("midreset_buf35", 6'd35, 20'h0);
    // FSM must be idle: a full block without start is ignored
    send_block(6'd0, mv(8, -4), 5);
    quiet();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: busy_o=%b expected 0", busy_o);
    end
    read_chk("idle_ignored", 6'd0, 20'h0);
  endtask

  initial begin
    test_reset();
    test_half_pass();
    test_quar_pass();
    test_wrap();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
